// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between IF and ID.
// Holds {pc, instr} pairs in a small circular buffer, hands them to decode
// in order through valid/ready, holds the PC while the buffer is full and
// handles branch redirects, optionally keeping one delay-slot instruction.
module fetch_queue #(
  parameter int          DEPTH    = 2,
  parameter int          ADDR_W   = 1,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_instr,
  output logic              if_stall,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc8,
  output logic [31:0]       id_instr,
  input  logic              flush,
  input  logic              flush_keep,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   ZERO_CNT = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

  logic [31:0]       pc_mem_q    [DEPTH];
  logic [31:0]       instr_mem_q [DEPTH];

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;

  logic              push_s;
  logic              pop_s;
  logic              we_s;
  logic [ADDR_W-1:0] rd_after_pop_s;
  logic [ADDR_W:0]   remain_s;

  // Stall and valid come straight from the registered occupancy count,
  // so id_ready never reaches if_stall combinationally.
  assign if_stall = (count_q == FULL_CNT);
  assign id_valid = (count_q != ZERO_CNT);
  assign count    = count_q;

  assign push_s = if_valid & ~if_stall;
  assign pop_s  = id_valid & id_ready;

  // Head position and occupancy as they stand once this cycle's pop is taken.
  assign rd_after_pop_s = pop_s ? (rd_ptr_q + ONE_PTR) : rd_ptr_q;
  assign remain_s       = count_q - {{ADDR_W{1'b0}}, pop_s};

  // Next pointer/count state; flush overrides the normal push/pop update.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    we_s     = 1'b0;
    if (flush) begin
      if (flush_keep) begin
        if (remain_s != ZERO_CNT) begin
          // Oldest entry left after the pop is the delay slot.
          rd_ptr_d = rd_after_pop_s;
          wr_ptr_d = rd_after_pop_s + ONE_PTR;
          count_d  = ONE_CNT;
        end else if (push_s) begin
          // Nothing queued survives; the incoming fetch is the delay slot.
          we_s     = 1'b1;
          rd_ptr_d = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + ONE_PTR;
          count_d  = ONE_CNT;
        end else begin
          rd_ptr_d = wr_ptr_q;
          wr_ptr_d = wr_ptr_q;
          count_d  = ZERO_CNT;
        end
      end else begin
        rd_ptr_d = wr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = ZERO_CNT;
      end
    end else begin
      we_s     = push_s;
      rd_ptr_d = rd_after_pop_s;
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + ONE_PTR;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d  = count_q + {{ADDR_W{1'b0}}, push_s} - {{ADDR_W{1'b0}}, pop_s};
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      pc_mem_q[wr_ptr_q]    <= if_pc;
      instr_mem_q[wr_ptr_q] <= if_instr;
    end
  end

  // Head-of-queue output mux; an empty queue shows a nop at RESET_PC.
  always_comb begin
    if (id_valid) begin
      id_pc    = pc_mem_q[rd_ptr_q];
      id_instr = instr_mem_q[rd_ptr_q];
    end else begin
      id_pc    = RESET_PC;
      id_instr = 32'h0000_0000;
    end
  end

  assign id_pc8 = id_pc + 32'd8;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, a steady-stream sequence,
// then randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 2;
  localparam int ADDR_W = 1;
  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, if_valid, id_ready, flush, flush_keep;
  logic [31:0] if_pc, if_instr;
  logic        if_stall, id_valid;
  logic [31:0] id_pc, id_pc8, id_instr;
  logic [ADDR_W:0] count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .if_stall(if_stall), .id_ready(id_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc8(id_pc8), .id_instr(id_instr),
    .flush(flush), .flush_keep(flush_keep), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return {pc[15:0], 16'hC0DE} ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                       input logic rdy, input logic f, input logic k);
    reset = r; if_valid = v; if_pc = pc; if_instr = ins_of(pc);
    id_ready = rdy; flush = f; flush_keep = k;
  endtask

  // Compare all outputs against an expected head state.
  task automatic chk_state(input string tag, input int c, input logic st,
                           input logic v, input logic [31:0] pc);
    chk({tag, ".count"},    32'(count),    32'(c));
    chk({tag, ".if_stall"}, 32'(if_stall), 32'(st));
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(v));
    chk({tag, ".id_pc"},    id_pc,         pc);
    chk({tag, ".id_pc8"},   id_pc8,        pc + 32'd8);
    chk({tag, ".id_instr"}, id_instr,      v ? ins_of(pc) : 32'h0);
  endtask

  typedef struct {
    logic        r, v, rdy, f, k;
    logic [31:0] pc;
    int          e_cnt;
    logic        e_st, e_v;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[20];
  logic [63:0] mq[$];

  // Reference model step, following the behavioural rules directly.
  task automatic model_step(input logic r, input logic v, input logic [31:0] pc,
                            input logic rdy, input logic f, input logic k);
    bit push, pop;
    push = v && (mq.size() < DEPTH);
    pop  = rdy && (mq.size() != 0);
    if (r) begin
      mq.delete();
    end else if (f) begin
      if (pop) void'(mq.pop_front());
      if (k && mq.size() != 0) begin
        while (mq.size() > 1) void'(mq.pop_back());
      end else if (k && push) begin
        mq.push_back({pc, ins_of(pc)});
      end else begin
        mq.delete();
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({pc, ins_of(pc)});
    end
  endtask

  initial begin
    logic [31:0] pc_r;
    bit r, v, rdy, f, k;
    int cyc;

    //          r  v  rdy f  k  pc            cnt st v  id_pc
    vt[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,         0,1'b0,1'b0,32'h3000};
    vt[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h3000,      1,1'b0,1'b1,32'h3000};
    vt[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h3004,      2,1'b1,1'b1,32'h3000};
    vt[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h3008,      2,1'b1,1'b1,32'h3000};
    vt[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h3008,      1,1'b0,1'b1,32'h3004};
    vt[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h3008,      2,1'b1,1'b1,32'h3004};
    vt[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,         1,1'b0,1'b1,32'h3008};
    vt[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,         0,1'b0,1'b0,32'h3000};
    vt[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h3010,      1,1'b0,1'b1,32'h3010};
    vt[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h3014,      2,1'b1,1'b1,32'h3010};
    vt[10] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 32'h3018,      1,1'b0,1'b1,32'h3014};
    vt[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,         0,1'b0,1'b0,32'h3000};
    vt[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h3020,      1,1'b0,1'b1,32'h3020};
    vt[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h3024,      2,1'b1,1'b1,32'h3020};
    vt[14] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 32'h3028,      0,1'b0,1'b0,32'h3000};
    vt[15] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 32'h3030,      1,1'b0,1'b1,32'h3030};
    vt[16] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 32'h3034,      1,1'b0,1'b1,32'h3034};
    vt[17] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 32'h3038,      1,1'b0,1'b1,32'h3034};
    vt[18] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h303C,      2,1'b1,1'b1,32'h3034};
    vt[19] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h3040,      0,1'b0,1'b0,32'h3000};
    vt[19].r = 1'b1;

    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vt[i].r, vt[i].v, vt[i].pc, vt[i].rdy, vt[i].f, vt[i].k);
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vt[i].e_cnt, vt[i].e_st, vt[i].e_v, vt[i].e_pc);
    end

    // Steady push+pop stream: count stays 1 while pointers wrap.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h3000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_state($sformatf("stream%0d", i), 1, 1'b0, 1'b1, 32'h3000 + 32'(4 * i));
      drive(1'b0, 1'b1, 32'h3004 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      @(posedge clk);
    end

    // Randomized traffic against the reference model.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    model_step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    pc_r = 32'h0000_4000;
    for (cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (mq.size() == 0) chk_state($sformatf("rnd%0d", cyc), 0, 1'b0, 1'b0, RPC);
      else chk_state($sformatf("rnd%0d", cyc), mq.size(), mq.size() == DEPTH, 1'b1, mq[0][63:32]);
      checks++;
      if (count > (ADDR_W+1)'(DEPTH)) begin
        errors++;
        $display("FAIL count_bound got %0d expected <= %0d", count, DEPTH);
      end
      r   = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      f   = ($urandom_range(0, 7) == 0);
      k   = $urandom_range(0, 1) != 0;
      drive(r, v, pc_r, rdy, f, k);
      model_step(r, v, pc_r, rdy, f, k);
      if (v && !if_stall) pc_r = pc_r + 32'd4;
      @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
